// File: rtl/dds_increment_slewer.sv
// Slews the DDS phase increment from its current value to a requested target in bounded steps
// at a programmed interval, pausing while the downstream MMCM is out of lock.
module dds_increment_slewer #(
  parameter int                   INC_WIDTH      = 32,
  parameter logic [INC_WIDTH-1:0] DEFAULT_INC    = 32'h33333333,
  parameter int                   INTERVAL_WIDTH = 16,
  parameter int                   LOCK_SYNC_FF   = 2
) (
  input  logic                      clk_ref,
  input  logic                      clk_ref_aresetn,
  input  logic [INC_WIDTH-1:0]      target_increment,
  input  logic [INC_WIDTH-1:0]      step_size,
  input  logic [INTERVAL_WIDTH-1:0] step_interval,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      PLL_locked,
  output logic [INC_WIDTH-1:0]      increment,
  output logic                      busy,
  output logic                      done,
  output logic                      lock_lost,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [INC_WIDTH-1:0]      inc_q, inc_d;
  logic [INC_WIDTH-1:0]      tgt_q, tgt_d;
  logic [INC_WIDTH-1:0]      step_q, step_d;
  logic [INTERVAL_WIDTH-1:0] reload_q, reload_d;
  logic [INTERVAL_WIDTH-1:0] cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      lock_lost_q, lock_lost_d;
  logic [LOCK_SYNC_FF-1:0]   lock_sync_q, lock_sync_d;

  logic                      lock_s;
  logic [INC_WIDTH-1:0]      diff;
  logic                      going_up;
  logic                      last_step;

  // PLL_locked is asynchronous to clk_ref; only the last stage is used by the FSM.
  assign lock_sync_d = {lock_sync_q[LOCK_SYNC_FF-2:0], PLL_locked};
  assign lock_s      = lock_sync_q[LOCK_SYNC_FF-1];

  // Distance to target is computed in magnitude form so no step can wrap past it.
  assign going_up  = (tgt_q >= inc_q);
  assign diff      = going_up ? (tgt_q - inc_q) : (inc_q - tgt_q);
  assign last_step = (diff <= step_q);

  // start is a request qualified by busy: it is taken only on a cycle where busy=0
  // and abort=0; while busy=1 any start is dropped and the latched parameters stand.
  always_comb begin
    state_d     = state_q;
    inc_d       = inc_q;
    tgt_d       = tgt_q;
    step_d      = step_q;
    reload_d    = reload_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    lock_lost_d = lock_lost_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          tgt_d       = target_increment;
          step_d      = (step_size == '0) ? INC_WIDTH'(1) : step_size;
          reload_d    = (step_interval == '0) ? '0 : (step_interval - 1'b1);
          cnt_d       = reload_d;
          lock_lost_d = 1'b0;
          if (target_increment == inc_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      // The update is committed on the edge leaving WAIT; STEP is the one-cycle gap
      // before the interval is reloaded, giving interval+1 cycles between updates.
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!lock_s) begin
          state_d     = S_HOLD;
          lock_lost_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (last_step) begin
          inc_d   = tgt_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          inc_d   = going_up ? (inc_q + step_q) : (inc_q - step_q);
          state_d = S_STEP;
        end
      end

      S_STEP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!lock_s) begin
          state_d     = S_HOLD;
          lock_lost_d = 1'b1;
        end else begin
          cnt_d   = reload_q;
          state_d = S_WAIT;
        end
      end

      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (lock_s) begin
          cnt_d   = reload_q;
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_ref or negedge clk_ref_aresetn) begin
    if (!clk_ref_aresetn) begin
      state_q     <= S_IDLE;
      inc_q       <= DEFAULT_INC;
      tgt_q       <= DEFAULT_INC;
      step_q      <= INC_WIDTH'(1);
      reload_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lock_lost_q <= 1'b0;
      lock_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      inc_q       <= inc_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      reload_q    <= reload_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lock_lost_q <= lock_lost_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign increment = inc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lock_lost = lock_lost_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dds_increment_slewer.sv
// Directed bench for dds_increment_slewer: every increment change or done pulse is matched
// against a queue of hand-computed {increment, done, cycle} entries.
module tb_dds_increment_slewer;

  localparam int W = 32 + 1 + 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] target_increment;
  logic [31:0] step_size;
  logic [15:0] step_interval;
  logic        start;
  logic        abort;
  logic        pll_locked;
  logic [31:0] increment;
  logic        busy;
  logic        done;
  logic        lock_lost;
  logic [1:0]  dbg_state;

  logic [31:0] cyc = '0;
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  dds_increment_slewer dut (
    .clk_ref          (clk),
    .clk_ref_aresetn  (rst_n),
    .target_increment (target_increment),
    .step_size        (step_size),
    .step_interval    (step_interval),
    .start            (start),
    .abort            (abort),
    .PLL_locked       (pll_locked),
    .increment        (increment),
    .busy             (busy),
    .done             (done),
    .lock_lost        (lock_lost),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d entries still queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] inc, input logic d, input logic [31:0] c);
    exp_q.push_back({inc, d, c});
  endtask

  task automatic do_start(input logic [31:0] tgt, input logic [31:0] stp,
                          input logic [15:0] ivl, output logic [31:0] k);
    target_increment = tgt;
    step_size        = stp;
    step_interval    = ivl;
    start            = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k     = cyc;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick(1);
      n++;
    end
    n_vec++;
    if (busy) begin
      n_err++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", max_cycles);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0]  prev_inc;
    logic [W-1:0] e;
    logic [W-1:0] act;
    prev_inc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_inc = increment;
      end else begin
        if (done) begin
          n_vec++;
          if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL done_idle: busy=%b state=%0d with done, expected busy=0 state=0",
                     busy, dbg_state);
          end
        end
        if (increment !== prev_inc || done) begin
          n_vec++;
          act = {increment, done, cyc};
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: inc=%h done=%b cycle=%0d, expected no event",
                     increment, done, cyc);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              n_err++;
              $display("FAIL event: got inc=%h done=%b cycle=%0d, expected inc=%h done=%b cycle=%0d",
                       increment, done, cyc, e[W-1 -: 32], e[32], e[31:0]);
            end
          end
        end
        prev_inc = increment;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] k;
    rst_n            = 1'b0;
    target_increment = '0;
    step_size        = '0;
    step_interval    = '0;
    start            = 1'b0;
    abort            = 1'b0;
    pll_locked       = 1'b1;

    // Reset state and a start with target equal to the current increment
    tick(3);
    check("reset_inc", increment, 32'h33333333);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_lock_lost", {31'b0, lock_lost}, 32'd0);
    rst_n = 1'b1;
    tick(4);
    do_start(32'h33333333, 32'd1, 16'd1, k);
    push(32'h33333333, 1'b1, k);
    check("same_target_busy", {31'b0, busy}, 32'd0);
    check("same_target_done", {31'b0, done}, 32'd1);
    tick(1);
    check("same_target_done_clear", {31'b0, done}, 32'd0);
    check("same_target_busy_after", {31'b0, busy}, 32'd0);
    tick(2);

    // Up-slew, step 4, interval 3
    do_start(32'h33333340, 32'd4, 16'd3, k);
    push(32'h33333337, 1'b0, k + 3);
    push(32'h3333333B, 1'b0, k + 7);
    push(32'h3333333F, 1'b0, k + 11);
    push(32'h33333340, 1'b1, k + 15);
    check("up_busy", {31'b0, busy}, 32'd1);
    wait_idle(40);
    check("up_final", increment, 32'h33333340);
    tick(2);

    // Down-slew with odd remainder, interval 0 behaves as 1
    do_start(32'h33333330, 32'h7, 16'd0, k);
    push(32'h33333339, 1'b0, k + 1);
    push(32'h33333332, 1'b0, k + 3);
    push(32'h33333330, 1'b1, k + 5);
    wait_idle(20);
    check("down_final", increment, 32'h33333330);
    tick(2);

    // Lock loss mid-slew
    do_start(32'h33333340, 32'd4, 16'd3, k);
    push(32'h33333334, 1'b0, k + 3);
    tick(4);
    pll_locked = 1'b0;
    tick(6);
    check("hold_inc", increment, 32'h33333334);
    check("hold_lock_lost", {31'b0, lock_lost}, 32'd1);
    check("hold_busy", {31'b0, busy}, 32'd1);
    tick(4);
    pll_locked = 1'b1;
    push(32'h33333338, 1'b0, k + 20);
    push(32'h3333333C, 1'b0, k + 24);
    push(32'h33333340, 1'b1, k + 28);
    wait_idle(40);
    check("lock_lost_sticky", {31'b0, lock_lost}, 32'd1);
    tick(2);

    // Abort after the second update; lock_lost cleared by the start
    do_start(32'h33333360, 32'd8, 16'd2, k);
    check("lock_lost_cleared", {31'b0, lock_lost}, 32'd0);
    push(32'h33333348, 1'b0, k + 2);
    push(32'h33333350, 1'b0, k + 5);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    tick(3);
    check("abort_inc_held", increment, 32'h33333350);

    // start together with abort in IDLE is ignored
    target_increment = 32'h0;
    step_size        = 32'd1;
    step_interval    = 16'd1;
    start            = 1'b1;
    abort            = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {31'b0, busy}, 32'd0);
    tick(2);
    check("start_abort_inc", increment, 32'h33333350);

    // start while busy is ignored; original target reached
    do_start(32'h33333370, 32'd8, 16'd2, k);
    push(32'h33333358, 1'b0, k + 2);
    push(32'h33333360, 1'b0, k + 5);
    push(32'h33333368, 1'b0, k + 8);
    push(32'h33333370, 1'b1, k + 11);
    tick(3);
    target_increment = 32'h0;
    step_size        = 32'hFFFFFFFF;
    step_interval    = 16'd0;
    start            = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(30);
    check("busy_start_final", increment, 32'h33333370);
    tick(2);

    // Extremes: huge step, top of range, step 0 as 1
    do_start(32'hFFFFFFF0, 32'hFFFFFFFF, 16'd0, k);
    push(32'hFFFFFFF0, 1'b1, k + 1);
    wait_idle(10);
    tick(2);
    do_start(32'hFFFFFFFF, 32'hFFFFFFFF, 16'd0, k);
    push(32'hFFFFFFFF, 1'b1, k + 1);
    wait_idle(10);
    check("top_final", increment, 32'hFFFFFFFF);
    tick(2);
    do_start(32'hFFFFFFFD, 32'd0, 16'd0, k);
    push(32'hFFFFFFFE, 1'b0, k + 1);
    push(32'hFFFFFFFD, 1'b1, k + 3);
    wait_idle(10);
    tick(2);

    // Reset mid-slew returns the increment to default immediately
    do_start(32'h0, 32'd1, 16'd5, k);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("midreset_inc", increment, 32'h33333333);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    do_start(32'h33333334, 32'd1, 16'd1, k);
    push(32'h33333334, 1'b1, k + 1);
    wait_idle(10);
    tick(5);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected events never seen, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
